pc_sequencer: RTL and testbench

//  Owns and sequences the fetch PC of the RISC-V core: selects next PC (reset vector, PC+4,

---
 rtl/riscv_pkg.sv | 14 +
 rtl/pc_sequencer_pc_reg.sv | 21 ++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch sequencer state encoding and core-wide defaults.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_BOOT   = 2'd1,
    S_RUN    = 2'd2,
    S_SQUASH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Fetch PC register: plain flop bank that loads the reset vector on a synchronous active-low reset.
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // Capture the next fetch address every edge; reset only via the clock edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_PC;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: picks the next fetch address, tags returning IMEM data with its PC,
// and inserts a bubble when a redirect/trap overrides a stall so ID never sees a split pair.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  fetch_inst,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  seq_state_t      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            steering;
  logic            accept;

  // Redirects and traps only steer the PC once the sequencer is past boot
  assign steering = (state == S_RUN) || (state == S_SQUASH);
  assign accept   = rst && steering && (trap_valid || redirect_valid);

  // Next-PC selection: trap over redirect over stall-hold over sequential; a squash
  // bubble re-presents the already fetched target instead of advancing past it
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    next_pc  = RESET_PC;
    if (rst) begin
      case (state)
        S_RUN: begin
          if (trap_valid)          next_pc = trap_pc;
          else if (redirect_valid) next_pc = redirect_pc;
          else if (stall)          next_pc = pc;
          else                     next_pc = pc_plus4;
        end
        S_SQUASH: begin
          if (trap_valid)          next_pc = trap_pc;
          else if (redirect_valid) next_pc = redirect_pc;
          else                     next_pc = pc;
        end
        default: next_pc = RESET_PC;
      endcase
    end
    imem_addr = {next_pc[XLEN-1:2], 2'b00};
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .d   (imem_addr),
    .q   (pc)
  );

  assign fetch_pc   = pc;
  assign fetch_inst = imem_rdata;

  // Sequencer FSM with registered fetch_valid; a redirect/trap under stall costs one bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_RESET;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state       <= S_BOOT;
          fetch_valid <= 1'b0;
        end
        S_BOOT: begin
          state       <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_RUN: begin
          if (accept && stall) begin
            state       <= S_SQUASH;
            fetch_valid <= 1'b0;
          end else begin
            state       <= S_RUN;
            fetch_valid <= 1'b1;
          end
        end
        S_SQUASH: begin
          if (accept) begin
            state       <= S_SQUASH;
            fetch_valid <= 1'b0;
          end else begin
            state       <= S_RUN;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          state       <= S_RESET;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters: clear beats increment, both wrap naturally
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if ((state == S_RUN) && stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (accept) begin
        squash_cnt <= squash_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a one-cycle-latency IMEM model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        cnt_clr;
  logic [31:0] stall_cnt;
  logic [31:0] squash_cnt;

  int          n_checks;
  int          n_fails;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .cnt_clr        (cnt_clr),
    .stall_cnt      (stall_cnt),
    .squash_cnt     (squash_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Content of the instruction memory at a given word address
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // Synchronous-read IMEM: data appears one edge after the address
  always @(posedge clk) imem_rdata <= imem_model(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rp,
                               input logic tv, input logic [31:0] tp, input logic cc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    trap_valid     = tv;
    trap_pc        = tp;
    cnt_clr        = cc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset held for three edges
    tick(); tick(); tick();
    checkOutput("rst_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("rst_pc", fetch_pc, RST_PC);
    checkOutput("rst_addr", imem_addr, RST_PC);
    checkOutput("rst_stallcnt", stall_cnt, 32'h0);
    checkOutput("rst_squashcnt", squash_cnt, 32'h0);

    // Release reset: boot cycle, redirect ignored, then first valid fetch
    rst = 1'b1;
    #1;
    checkOutput("rel_addr", imem_addr, RST_PC);
    tick();
    checkOutput("boot_valid", {31'b0, fetch_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    checkOutput("boot_ignore_redirect", imem_addr, RST_PC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("run0_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("run0_pc", fetch_pc, 32'h4000_0000);
    checkOutput("run0_inst", fetch_inst, imem_model(32'h4000_0000));
    checkOutput("run0_addr", imem_addr, 32'h4000_0004);

    // Free run
    tick();
    checkOutput("run1_pc", fetch_pc, 32'h4000_0004);
    tick();
    checkOutput("run2_pc", fetch_pc, 32'h4000_0008);
    checkOutput("run2_inst", fetch_inst, imem_model(32'h4000_0008));

    // Stall for three cycles at 0x4000_0008
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_addr", imem_addr, 32'h4000_0008);
    tick();
    checkOutput("stall1_cnt", stall_cnt, 32'h1);
    tick(); tick();
    checkOutput("stall3_pc", fetch_pc, 32'h4000_0008);
    checkOutput("stall3_inst", fetch_inst, imem_model(32'h4000_0008));
    checkOutput("stall3_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("stall3_cnt", stall_cnt, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("run3_pc", fetch_pc, 32'h4000_000C);
    checkOutput("run3_stallcnt", stall_cnt, 32'h3);

    // Plain redirect: target valid the next cycle
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_addr", imem_addr, 32'h0000_1000);
    tick();
    checkOutput("redir_pc", fetch_pc, 32'h0000_1000);
    checkOutput("redir_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("redir_squashcnt", squash_cnt, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("redir_next_pc", fetch_pc, 32'h0000_1004);

    // Redirect under stall: one bubble, then the target
    applyStimulus(1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    checkOutput("sredir_addr", imem_addr, 32'h0000_1000);
    tick();
    checkOutput("squash_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("squash_pc", fetch_pc, 32'h0000_1000);
    checkOutput("squash_cnt2", squash_cnt, 32'h2);
    checkOutput("squash_stallcnt", stall_cnt, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("squash_hold_addr", imem_addr, 32'h0000_1000);
    tick();
    checkOutput("post_squash_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("post_squash_pc", fetch_pc, 32'h0000_1000);
    checkOutput("post_squash_inst", fetch_inst, imem_model(32'h0000_1000));

    // Misaligned redirect target has its low bits dropped
    applyStimulus(1'b0, 1'b1, 32'h0000_3003, 1'b0, 32'h0, 1'b0);
    checkOutput("misalign_addr", imem_addr, 32'h0000_3000);
    tick();
    checkOutput("misalign_pc", fetch_pc, 32'h0000_3000);
    checkOutput("misalign_squashcnt", squash_cnt, 32'h3);

    // Trap and redirect together: trap wins, counted once
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_0200, 1'b0);
    checkOutput("trap_addr", imem_addr, 32'h0000_0200);
    tick();
    checkOutput("trap_pc", fetch_pc, 32'h0000_0200);
    checkOutput("trap_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("trap_squashcnt", squash_cnt, 32'h4);

    // Counter clear has priority over a concurrent stall increment
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("clr_stallcnt", stall_cnt, 32'h0);
    checkOutput("clr_squashcnt", squash_cnt, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("after_clr_stallcnt", stall_cnt, 32'h1);

    // PC wraps from the top of the address space to zero
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_top_pc", fetch_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_squashcnt", squash_cnt, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
    tick();
    checkOutput("wrap_pc", fetch_pc, 32'h0000_0000);

    // Reset asserted in the middle of a stall plus redirect
    applyStimulus(1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_addr", imem_addr, RST_PC);
    tick();
    checkOutput("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("mid_rst_pc", fetch_pc, RST_PC);
    checkOutput("mid_rst_stallcnt", stall_cnt, 32'h0);
    checkOutput("mid_rst_squashcnt", squash_cnt, 32'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("reboot_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    checkOutput("rerun_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("rerun_pc", fetch_pc, RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
